// File: rtl/eth_rx_arb_pkg.sv
// eth_rx_arb_pkg: shared types and helpers for the eth RX NoC-out arbiter.
//   - arb_state_e : arbiter FSM state (IDLE / GRANTED)
//   - rr_winner() : rotated-priority search over a request vector
package eth_rx_arb_pkg;

  // Default flit width of the noc0 vrtoc port.
  localparam int NOC_DATA_W_DEF = 512;

  // Widest request vector the picker supports.
  localparam int MAX_SRC = 8;

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } arb_state_e;

  // Returns the first set bit of req at or above ptr, wrapping at num_src.
  // ptr is always < num_src, so one conditional subtract keeps the probe
  // index in range without a modulo operator.
  function automatic logic [2:0] rr_winner(input logic [MAX_SRC-1:0] req,
                                           input logic [2:0]         ptr,
                                           input int                 num_src);
    logic [2:0] win;
    logic       found;
    logic [3:0] probe;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_SRC; i++) begin
      probe = {1'b0, ptr} + 4'(i);
      if (probe >= 4'(num_src)) begin
        probe = probe - 4'(num_src);
      end
      if ((i < num_src) && !found && req[probe[2:0]]) begin
        win   = probe[2:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/eth_rx_noc_out_arb_rr_prio_picker.sv
// rr_prio_picker: combinational rotated-priority picker.
//   req        in  NUM_SRC    request vector
//   ptr        in  SRC_IDX_W  highest-priority index this cycle
//   winner_idx out SRC_IDX_W  first requester at or after ptr (wrapping)
//   any_req    out 1          at least one request is set
module rr_prio_picker
  import eth_rx_arb_pkg::*;
#(
  parameter int NUM_SRC   = 2,
  parameter int SRC_IDX_W = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0]   req,
  input  logic [SRC_IDX_W-1:0] ptr,
  output logic [SRC_IDX_W-1:0] winner_idx,
  output logic                 any_req
);

  logic [MAX_SRC-1:0] req_ext;
  logic [2:0]         ptr_ext;
  logic [2:0]         win_full;

  assign req_ext    = MAX_SRC'(req);
  assign ptr_ext    = 3'(ptr);
  assign win_full   = rr_winner(req_ext, ptr_ext, NUM_SRC);
  assign winner_idx = win_full[SRC_IDX_W-1:0];
  assign any_req    = |req;

endmodule

// File: rtl/eth_rx_noc_out_arb.sv
// eth_rx_noc_out_arb: packet-granular round-robin arbiter sharing one noc0
// vrtoc output among NUM_SRC eth RX NoC-out controllers. A granted source
// owns the port until its last flit handshakes; packets never interleave.
//   clk, rst                 clock, asynchronous active-high reset
//   src_arb_val/data/last    per-source flit streams (data flattened)
//   arb_src_rdy              per-source ready (only the owner can see rdy)
//   arb_noc0_vrtoc_val/data  flit to the NoC router
//   noc0_vrtoc_arb_rdy       NoC ready
//   arb_grant_vec            one-hot current owner, zero while arbitrating
//   arb_pkt_done             pulse on the handshake of a last flit
module eth_rx_noc_out_arb
  import eth_rx_arb_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int NOC_DATA_W = NOC_DATA_W_DEF,
  parameter int SRC_IDX_W  = $clog2(NUM_SRC)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            src_arb_val,
  input  logic [NUM_SRC*NOC_DATA_W-1:0] src_arb_data,
  input  logic [NUM_SRC-1:0]            src_arb_last,
  output logic [NUM_SRC-1:0]            arb_src_rdy,
  output logic                          arb_noc0_vrtoc_val,
  output logic [NOC_DATA_W-1:0]         arb_noc0_vrtoc_data,
  input  logic                          noc0_vrtoc_arb_rdy,
  output logic [NUM_SRC-1:0]            arb_grant_vec,
  output logic                          arb_pkt_done
);

  arb_state_e           state_reg, state_next;
  logic [SRC_IDX_W-1:0] grant_idx_reg, grant_idx_next;
  logic [SRC_IDX_W-1:0] rr_ptr_reg, rr_ptr_next;
  logic [SRC_IDX_W-1:0] winner_idx;
  logic                 any_req;
  logic [NOC_DATA_W-1:0] src_data [NUM_SRC];

  rr_prio_picker #(
    .NUM_SRC  (NUM_SRC),
    .SRC_IDX_W(SRC_IDX_W)
  ) u_picker (
    .req       (src_arb_val),
    .ptr       (rr_ptr_reg),
    .winner_idx(winner_idx),
    .any_req   (any_req)
  );

  // Per-source slicing, ownership decode and ready steering. Ready is only
  // ever routed to the owner, so other sources see a stall while GRANTED.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign src_data[gi]      = src_arb_data[gi*NOC_DATA_W +: NOC_DATA_W];
    assign arb_grant_vec[gi] = (state_reg == GRANTED) &&
                               (grant_idx_reg == SRC_IDX_W'(gi));
    assign arb_src_rdy[gi]   = arb_grant_vec[gi] & noc0_vrtoc_arb_rdy;
  end

  always_comb begin
    state_next          = state_reg;
    grant_idx_next      = grant_idx_reg;
    rr_ptr_next         = rr_ptr_reg;
    arb_noc0_vrtoc_val  = 1'b0;
    arb_noc0_vrtoc_data = '0;
    arb_pkt_done        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          grant_idx_next = winner_idx;
          state_next     = GRANTED;
        end
      end
      GRANTED: begin
        arb_noc0_vrtoc_val  = src_arb_val[grant_idx_reg];
        arb_noc0_vrtoc_data = src_data[grant_idx_reg];
        if (src_arb_val[grant_idx_reg] && noc0_vrtoc_arb_rdy &&
            src_arb_last[grant_idx_reg]) begin
          arb_pkt_done = 1'b1;
          // Explicit wrap keeps the pointer in range for non-power-of-two
          // source counts.
          rr_ptr_next  = (grant_idx_reg == SRC_IDX_W'(NUM_SRC-1)) ?
                         '0 : grant_idx_reg + 1'b1;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      grant_idx_reg <= '0;
      rr_ptr_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      grant_idx_reg <= grant_idx_next;
      rr_ptr_reg    <= rr_ptr_next;
    end
  end

endmodule
